// File: rtl/encap_pkg.sv
// Shared definitions for the encapsulation result read-out path: parameter-set
// tables, output source tags, read-out FSM states and the buffered word type.
package encap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_C0 = 2'd0;
  localparam logic [1:0] SEL_C1 = 2'd1;
  localparam logic [1:0] SEL_K  = 2'd2;

  typedef struct packed {
    logic [1:0]  sel;
    logic        last;
    logic [31:0] data;
  } out_word_t;

  // Code length n for mceliece348864/460896/6688128/6960119/8192128.
  function automatic int n_of(input int ps);
    case (ps)
      1:       return 3488;
      2:       return 4608;
      3:       return 6688;
      4:       return 6960;
      default: return 8192;
    endcase
  endfunction

  // Field degree m.
  function automatic int m_of(input int ps);
    return (ps == 1) ? 12 : 13;
  endfunction

  // Error weight t.
  function automatic int t_of(input int ps);
    case (ps)
      1:       return 64;
      2:       return 96;
      3:       return 128;
      4:       return 119;
      default: return 128;
    endcase
  endfunction

  // Number of 32-bit words holding the m*t-bit syndrome C0.
  function automatic int c0_words_of(input int ps);
    return (m_of(ps) * t_of(ps) + 31) / 32;
  endfunction

endpackage

// File: rtl/encap_out_fifo.sv
// Two-entry first-word-fall-through buffer for tagged output words.
// The head entry is always visible on dout; count tells whether it is valid.
module encap_out_fifo
  import encap_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  out_word_t din,
  output out_word_t dout,
  output logic [1:0] count
);

  out_word_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  // Storage, pointers and occupancy; the reader never pushes into a full buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/encap_result_reader.sv
// Unloads C0, C1 and the session key K from the encapsulation core after
// completion and streams them as tagged 32-bit words over valid/ready.
// Reads have one cycle of latency, so a tag register follows each read and a
// two-entry buffer absorbs backpressure while still allowing one word/cycle.
module encap_result_reader
  import encap_pkg::*;
#(
  parameter int  parameter_set = 1,
  parameter int  m             = m_of(parameter_set),
  parameter int  t             = t_of(parameter_set),
  parameter int  l             = m * t,
  parameter int  C0_WORDS      = (l + 31) / 32,
  parameter int  C1_WORDS      = 8,
  parameter int  K_WORDS       = 8,
  localparam int C0_AW         = $clog2(C0_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rd_C0,
  output logic [C0_AW-1:0] C0_addr,
  input  logic [31:0]      C0_out,
  output logic             rd_C1,
  output logic [2:0]       C1_addr,
  input  logic [31:0]      C1_out,
  output logic             rd_K,
  output logic [2:0]       K_addr,
  input  logic [31:0]      K_out,
  output logic [31:0]      dout,
  output logic [1:0]       dout_sel,
  output logic             dout_last,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cur_sel;
  logic [C0_AW-1:0] c0_cnt;
  logic [2:0]       c1_cnt;
  logic [2:0]       k_cnt;
  logic             infl_valid;
  logic [1:0]       infl_sel;
  logic             infl_last;
  logic [1:0]       fifo_count;
  logic [2:0]       occupancy;
  logic             pop;
  logic             can_issue;
  logic             issue;
  logic             issue_last;
  out_word_t        push_word;
  out_word_t        head_word;

  assign dout_valid = (fifo_count != 2'd0);
  assign pop        = dout_valid & dout_ready;
  // Words already buffered plus the one in flight, minus the one leaving now.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, infl_valid} - {2'b00, pop};
  assign can_issue  = (occupancy < 3'd2);
  assign issue      = (state == ST_ISSUE) && can_issue;
  assign issue_last = issue && (cur_sel == SEL_K) && (k_cnt == 3'(K_WORDS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; DRAIN leaves as the final word is taken so done follows it directly.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!infl_valid &&
                    ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
                  state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: one read strobe per issued word, status flags from the state.
  always_comb begin
    rd_C0 = 1'b0;
    rd_C1 = 1'b0;
    rd_K  = 1'b0;
    busy  = (state != ST_IDLE);
    done  = (state == ST_FIN);
    if (issue) begin
      case (cur_sel)
        SEL_C0:  rd_C0 = 1'b1;
        SEL_C1:  rd_C1 = 1'b1;
        default: rd_K  = 1'b1;
      endcase
    end
  end

  // Address counters and current source; cleared whenever not issuing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_sel <= SEL_C0;
      c0_cnt  <= '0;
      c1_cnt  <= '0;
      k_cnt   <= '0;
    end else if (state != ST_ISSUE) begin
      cur_sel <= SEL_C0;
      c0_cnt  <= '0;
      c1_cnt  <= '0;
      k_cnt   <= '0;
    end else if (issue) begin
      case (cur_sel)
        SEL_C0: begin
          if (c0_cnt == C0_AW'(C0_WORDS - 1)) cur_sel <= SEL_C1;
          else                                c0_cnt  <= c0_cnt + 1'b1;
        end
        SEL_C1: begin
          if (c1_cnt == 3'(C1_WORDS - 1)) cur_sel <= SEL_K;
          else                            c1_cnt  <= c1_cnt + 1'b1;
        end
        default: begin
          if (k_cnt != 3'(K_WORDS - 1)) k_cnt <= k_cnt + 1'b1;
        end
      endcase
    end
  end

  assign C0_addr = c0_cnt;
  assign C1_addr = c1_cnt;
  assign K_addr  = k_cnt;

  // In-flight tag: remembers which memory answers next cycle and whether it is the final word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_valid <= 1'b0;
      infl_sel   <= SEL_C0;
      infl_last  <= 1'b0;
    end else begin
      infl_valid <= issue;
      infl_sel   <= cur_sel;
      infl_last  <= issue_last;
    end
  end

  // Capture mux: the C0 tail word is forwarded exactly as stored.
  always_comb begin
    push_word.sel  = infl_sel;
    push_word.last = infl_last;
    case (infl_sel)
      SEL_C0:  push_word.data = C0_out;
      SEL_C1:  push_word.data = C1_out;
      default: push_word.data = K_out;
    endcase
  end

  encap_out_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_valid),
    .pop   (pop),
    .din   (push_word),
    .dout  (head_word),
    .count (fifo_count)
  );

  assign dout      = head_word.data;
  assign dout_sel  = head_word.sel;
  assign dout_last = head_word.last;

endmodule

// File: tb/tb_encap_result_reader.sv
// Bench for encap_result_reader: a set-1 and a set-4 instance, behavioural
// memories, a word-order reference built from the memory contents, and a
// negedge monitor watching issue order, stalls and handshakes.
module tb_encap_result_reader;
  import encap_pkg::*;

  localparam int NC0_A     = 24;
  localparam int NC0_B     = 49;
  localparam int MODE_ON   = 0;
  localparam int MODE_RAND = 1;
  localparam int MODE_HOLD = 2;

  typedef struct {
    bit use_b;
    int mode;
    int extra_start;
    int exp_words;
    int exp_valid_edges;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  bit   use_b = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;

  logic start_a, ready_a, start_b, ready_b;
  assign start_a = start & ~use_b;
  assign ready_a = ready & ~use_b;
  assign start_b = start & use_b;
  assign ready_b = ready & use_b;

  logic        rd_c0_a, rd_c1_a, rd_k_a, last_a, valid_a, busy_a, done_a;
  logic [4:0]  c0_addr_a;
  logic [2:0]  c1_addr_a, k_addr_a;
  logic [31:0] c0_out_a = '0, c1_out_a = '0, k_out_a = '0, dout_a;
  logic [1:0]  sel_a;

  logic        rd_c0_b, rd_c1_b, rd_k_b, last_b, valid_b, busy_b, done_b;
  logic [5:0]  c0_addr_b;
  logic [2:0]  c1_addr_b, k_addr_b;
  logic [31:0] c0_out_b = '0, c1_out_b = '0, k_out_b = '0, dout_b;
  logic [1:0]  sel_b;

  logic [31:0] mem_c0_a [NC0_A];
  logic [31:0] mem_c0_b [NC0_B];
  logic [31:0] mem_c1 [8];
  logic [31:0] mem_k [8];

  encap_result_reader #(.parameter_set(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .rd_C0(rd_c0_a), .C0_addr(c0_addr_a), .C0_out(c0_out_a),
    .rd_C1(rd_c1_a), .C1_addr(c1_addr_a), .C1_out(c1_out_a),
    .rd_K(rd_k_a), .K_addr(k_addr_a), .K_out(k_out_a),
    .dout(dout_a), .dout_sel(sel_a), .dout_last(last_a), .dout_valid(valid_a),
    .dout_ready(ready_a), .busy(busy_a), .done(done_a)
  );

  encap_result_reader #(.parameter_set(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .rd_C0(rd_c0_b), .C0_addr(c0_addr_b), .C0_out(c0_out_b),
    .rd_C1(rd_c1_b), .C1_addr(c1_addr_b), .C1_out(c1_out_b),
    .rd_K(rd_k_b), .K_addr(k_addr_b), .K_out(k_out_b),
    .dout(dout_b), .dout_sel(sel_b), .dout_last(last_b), .dout_valid(valid_b),
    .dout_ready(ready_b), .busy(busy_b), .done(done_b)
  );

  // Behavioural result memories with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_c0_a) c0_out_a <= mem_c0_a[c0_addr_a];
    if (rd_c1_a) c1_out_a <= mem_c1[c1_addr_a];
    if (rd_k_a)  k_out_a  <= mem_k[k_addr_a];
    if (rd_c0_b) c0_out_b <= mem_c0_b[c0_addr_b];
    if (rd_c1_b) c1_out_b <= mem_c1[c1_addr_b];
    if (rd_k_b)  k_out_b  <= mem_k[k_addr_b];
  end

  // Observation mux onto whichever instance the current test drives.
  logic        obs_rd_c0, obs_rd_c1, obs_rd_k, obs_last, obs_valid, obs_busy, obs_done;
  logic [5:0]  obs_c0_addr;
  logic [2:0]  obs_c1_addr, obs_k_addr;
  logic [31:0] obs_dout;
  logic [1:0]  obs_sel;
  always_comb begin
    if (use_b) begin
      obs_rd_c0 = rd_c0_b; obs_rd_c1 = rd_c1_b; obs_rd_k = rd_k_b;
      obs_c0_addr = c0_addr_b; obs_c1_addr = c1_addr_b; obs_k_addr = k_addr_b;
      obs_dout = dout_b; obs_sel = sel_b; obs_last = last_b; obs_valid = valid_b;
      obs_busy = busy_b; obs_done = done_b;
    end else begin
      obs_rd_c0 = rd_c0_a; obs_rd_c1 = rd_c1_a; obs_rd_k = rd_k_a;
      obs_c0_addr = {1'b0, c0_addr_a}; obs_c1_addr = c1_addr_a; obs_k_addr = k_addr_a;
      obs_dout = dout_a; obs_sel = sel_a; obs_last = last_a; obs_valid = valid_a;
      obs_busy = busy_a; obs_done = done_a;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor state.
  int          nc0 = NC0_A;
  int          issued, hs_count, done_count;
  int          first_valid_cycle, first_hs_cycle, last_hs_cycle, done_cycle;
  logic [34:0] got_q [$];
  logic [34:0] exp_q [$];
  bit          stall_prev;
  logic [34:0] stall_word;

  task automatic clear_monitor();
    issued = 0; hs_count = 0; done_count = 0;
    first_valid_cycle = -1; first_hs_cycle = -1; last_hs_cycle = -1; done_cycle = -1;
    got_q.delete();
    stall_prev = 1'b0;
    stall_word = '0;
  endtask

  // Reference stream: every C0 word, then C1, then K, last flag on the final K word.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < nc0; i++)
      exp_q.push_back({SEL_C0, 1'b0, use_b ? mem_c0_b[i] : mem_c0_a[i]});
    for (int i = 0; i < 8; i++) exp_q.push_back({SEL_C1, 1'b0, mem_c1[i]});
    for (int i = 0; i < 8; i++) exp_q.push_back({SEL_K, (i == 7), mem_k[i]});
  endtask

  // The n-th read must target C0 0..nc0-1, then C1 0..7, then K 0..7.
  function automatic logic [8:0] expected_issue(input int idx);
    if (idx < nc0)      return {3'b100, 6'(idx)};
    if (idx < nc0 + 8)  return {3'b010, 6'(idx - nc0)};
    if (idx < nc0 + 16) return {3'b001, 6'(idx - nc0 - 8)};
    return 9'h1ff;
  endfunction

  // Negedge monitor: read order, outstanding reads, stall stability, handshakes, done.
  always @(negedge clk) begin
    logic [5:0] addr;
    if (rst) begin
      if (obs_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
      if (stall_prev)
        checkOutput("stall_hold", {obs_valid, obs_sel, obs_last, obs_dout}, {1'b1, stall_word});
      stall_prev = obs_valid && !ready;
      stall_word = {obs_sel, obs_last, obs_dout};
      if (obs_rd_c0 | obs_rd_c1 | obs_rd_k) begin
        addr = obs_rd_c0 ? obs_c0_addr : obs_rd_c1 ? {3'b000, obs_c1_addr} : {3'b000, obs_k_addr};
        checkOutput($sformatf("issue%0d", issued),
                    {obs_rd_c0, obs_rd_c1, obs_rd_k, addr}, expected_issue(issued));
        issued++;
      end
      if (obs_valid && ready) begin
        got_q.push_back({obs_sel, obs_last, obs_dout});
        if (hs_count == 0) first_hs_cycle = cycle;
        last_hs_cycle = cycle;
        hs_count++;
      end
      if (obs_rd_c0 | obs_rd_c1 | obs_rd_k)
        checkOutput("outstanding_le2", 64'((issued - hs_count) <= 2), 64'd1);
      if (obs_done) begin
        done_count++;
        done_cycle = cycle;
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rst_reads"},
                {obs_rd_c0, obs_rd_c1, obs_rd_k, obs_c0_addr, obs_c1_addr, obs_k_addr}, 64'd0);
    checkOutput({tag, "_rst_outs"},
                {obs_dout, obs_sel, obs_last, obs_valid, obs_busy, obs_done}, 64'd0);
  endtask

  // Runs one complete transfer from a start pulse and scores it against the reference.
  task automatic applyStimulus(input vec_t v);
    int  start_cycle;
    int  cyc;
    bit  extra_done;
    int  n;
    use_b = v.use_b;
    nc0   = v.use_b ? NC0_B : NC0_A;
    build_expected();
    clear_monitor();
    @(posedge clk); #1;
    start = 1'b1;
    ready = (v.mode == MODE_ON);
    @(posedge clk); #1;
    start       = 1'b0;
    start_cycle = cycle;
    cyc         = 0;
    extra_done  = 1'b0;
    while (done_count == 0 && cyc < 400) begin
      if (cyc == 5) checkOutput("busy_mid", obs_busy, 1'b1);
      if (v.mode == MODE_HOLD && cyc == 20) begin
        checkOutput("hold_reads", issued, 2);
        checkOutput("hold_dout", {obs_valid, obs_dout}, {1'b1, mem_c0_a[0]});
      end
      case (v.mode)
        MODE_ON:   ready = 1'b1;
        MODE_RAND: ready = 1'($urandom_range(0, 1));
        default:   ready = (cyc >= 20);
      endcase
      if (v.extra_start > 0 && !extra_done && hs_count >= v.extra_start) begin
        start      = 1'b1;
        extra_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_pulses", done_count, 1);
    checkOutput("busy_after", obs_busy, 1'b0);
    checkOutput("valid_latency", first_valid_cycle - start_cycle, v.exp_valid_edges);
    checkOutput("word_count", hs_count, v.exp_words);
    checkOutput("done_after_last", done_cycle - last_hs_cycle, 1);
    if (v.mode == MODE_ON) begin
      checkOutput("no_bubbles", last_hs_cycle - first_hs_cycle, v.exp_words - 1);
      checkOutput("first_hs_at_valid", first_hs_cycle, first_valid_cycle);
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("word%0d", i), got_q[i], exp_q[i]);
  endtask

  vec_t vecs [6];

  initial begin
    int cyc;
    int done_before;
    vecs[0] = '{use_b: 1'b0, mode: MODE_ON,   extra_start: 0,  exp_words: 40, exp_valid_edges: 2};
    vecs[1] = '{use_b: 1'b1, mode: MODE_ON,   extra_start: 0,  exp_words: 65, exp_valid_edges: 2};
    vecs[2] = '{use_b: 1'b0, mode: MODE_RAND, extra_start: 0,  exp_words: 40, exp_valid_edges: 2};
    vecs[3] = '{use_b: 1'b0, mode: MODE_HOLD, extra_start: 0,  exp_words: 40, exp_valid_edges: 2};
    vecs[4] = '{use_b: 1'b0, mode: MODE_ON,   extra_start: 10, exp_words: 40, exp_valid_edges: 2};
    vecs[5] = '{use_b: 1'b1, mode: MODE_RAND, extra_start: 0,  exp_words: 65, exp_valid_edges: 2};

    for (int i = 0; i < NC0_A; i++) mem_c0_a[i] = 32'hC000_0000 + 32'(i);
    for (int i = 0; i < NC0_B; i++) mem_c0_b[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      mem_c1[i] = 32'hC100_0000 + 32'(i);
      mem_k[i]  = 32'h4B00_0000 + 32'(i);
    end
    clear_monitor();

    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    use_b = 1'b0; #1 checkResetState("a");
    use_b = 1'b1; #1 checkResetState("b");
    use_b = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Mid-transfer reset on the set-1 instance, then a fresh run.
    use_b = 1'b0;
    nc0   = NC0_A;
    clear_monitor();
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (hs_count < 15 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("reached_word15", 64'(hs_count >= 15), 64'd1);
    rst = 1'b0;
    #1;
    checkResetState("midrst");
    done_before = done_count;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("midrst_hold");
    rst = 1'b1;
    ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", done_count, done_before);
    applyStimulus(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
